// File: rtl/battleship_pkg.sv
// battleship_pkg: shared FSM state encoding, board defaults, LFSR seed and cell-index helper.
package battleship_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE = 3'd0;
  localparam state_t PICK = 3'd1;
  localparam state_t SCAN = 3'd2;
  localparam state_t THINK = 3'd3;
  localparam state_t FIRE = 3'd4;
  localparam state_t DONE = 3'd5;
  typedef logic [2:0] coord_t;
  localparam int DEF_ROWS = 5;
  localparam int DEF_COLS = 5;
  localparam int DEF_BOATS = 5;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  function automatic logic [5:0] cell_idx(coord_t r, coord_t c, int cols);
    return 6'(32'(r) * cols + 32'(c));
  endfunction
endpackage

// File: rtl/pc_shot_engine_if.sv
// pc_shot_engine_if: StateMachine-side control and shot-report signals of the PC shooter.
interface pc_shot_engine_if import battleship_pkg::*; #(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
);
  logic newGame;
  logic pcTurn;
  logic [ROWS*COLS-1:0] playerBoard;
  logic shotDone;
  coord_t shotRow;
  coord_t shotCol;
  logic shotHit;
  logic [2:0] playerBoats;
  logic pcWin;
  modport master (
    output newGame, pcTurn, playerBoard,
    input shotDone, shotRow, shotCol, shotHit, playerBoats, pcWin
  );
  modport slave (
    input newGame, pcTurn, playerBoard,
    output shotDone, shotRow, shotCol, shotHit, playerBoats, pcWin
  );
endinterface

// File: rtl/pc_shot_engine_lfsr8.sv
// lfsr8: free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) that reloads the seed if it ever reads zero.
module lfsr8 import battleship_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= LFSR_SEED;
    else q <= (q == 8'd0) ? LFSR_SEED : {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
endmodule

// File: rtl/pc_shot_engine.sv
// pc_shot_engine: computer-opponent shooter; picks an unshot cell (LFSR, then linear scan), thinks, fires.
// Optional PC_HUNT_EN: after a hit, probe the hit cell's up/right/down/left neighbours before random draws.
module pc_shot_engine import battleship_pkg::*; #(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int BOATS = DEF_BOATS,
  parameter int THINK_CYCLES = 50_000_000,
  parameter int MAX_TRIES = 16
) (
  input logic clk,
  input logic rst,
  pc_shot_engine_if.slave bus
);
  localparam int N = ROWS * COLS;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [3:0] R4 = 4'(ROWS);
  localparam logic [3:0] C4 = 4'(COLS);
  state_t state;
  logic [7:0] lfsr;
  logic [N-1:0] mask;
  logic [TW-1:0] tries;
  logic [31:0] cnt;
  coord_t cur_r, cur_c;
  logic [IW-1:0] cand_i, cur_i;
  logic cand_ok, scan_end, unused_lfsr;
  lfsr8 u_lfsr (.clk(clk), .rst_n(rst), .q(lfsr));
  assign unused_lfsr = ^lfsr[7:6];
  assign cand_i = IW'(cell_idx(lfsr[2:0], lfsr[5:3], COLS));
  assign cur_i = IW'(cell_idx(cur_r, cur_c, COLS));
  assign cand_ok = {1'b0, lfsr[2:0]} < R4 && {1'b0, lfsr[5:3]} < C4 && !mask[cand_i];
  assign scan_end = cur_r == 3'(ROWS - 1) && cur_c == 3'(COLS - 1);
`ifdef PC_HUNT_EN
  logic hunt_v, nb_ok;
  coord_t hunt_r, hunt_c;
  logic [1:0] hunt_d;
  logic [3:0] nb_r, nb_c;
  logic [IW-1:0] nb_i;
  // 4-bit neighbour math so that stepping off either edge lands outside the board
  assign nb_r = {1'b0, hunt_r} + (hunt_d == 2'd0 ? 4'hF : hunt_d == 2'd2 ? 4'h1 : 4'h0);
  assign nb_c = {1'b0, hunt_c} + (hunt_d == 2'd1 ? 4'h1 : hunt_d == 2'd3 ? 4'hF : 4'h0);
  assign nb_i = IW'(cell_idx(nb_r[2:0], nb_c[2:0], COLS));
  assign nb_ok = nb_r < R4 && nb_c < C4 && !mask[nb_i];
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      mask <= '0;
      tries <= '0;
      cnt <= '0;
      cur_r <= '0;
      cur_c <= '0;
      bus.shotDone <= 1'b0;
      bus.shotRow <= '0;
      bus.shotCol <= '0;
      bus.shotHit <= 1'b0;
      bus.playerBoats <= 3'(BOATS);
      bus.pcWin <= 1'b0;
`ifdef PC_HUNT_EN
      hunt_v <= 1'b0;
      hunt_r <= '0;
      hunt_c <= '0;
      hunt_d <= '0;
`endif
    end else if (bus.newGame) begin
      state <= IDLE;
      mask <= '0;
      bus.shotDone <= 1'b0;
      bus.shotRow <= '0;
      bus.shotCol <= '0;
      bus.shotHit <= 1'b0;
      bus.playerBoats <= 3'(BOATS);
      bus.pcWin <= 1'b0;
`ifdef PC_HUNT_EN
      hunt_v <= 1'b0;
`endif
    end else begin
      bus.shotDone <= 1'b0;
      bus.pcWin <= bus.playerBoats == 3'd0;
      cnt <= 32'(THINK_CYCLES - 1);
      case (state)
        IDLE: begin
          tries <= '0;
`ifdef PC_HUNT_EN
          hunt_d <= '0;
`endif
          if (bus.pcTurn && !bus.pcWin) state <= PICK;
        end
        PICK:
          if (!bus.pcTurn) state <= IDLE;
`ifdef PC_HUNT_EN
          else if (hunt_v) begin
            if (nb_ok) begin
              cur_r <= nb_r[2:0];
              cur_c <= nb_c[2:0];
              state <= THINK;
            end else begin
              hunt_d <= hunt_d + 2'd1;
              hunt_v <= hunt_d != 2'd3;
            end
          end
`endif
          else if (cand_ok) begin
            cur_r <= lfsr[2:0];
            cur_c <= lfsr[5:3];
            state <= THINK;
          end else if (tries == TW'(MAX_TRIES - 1)) begin
            cur_r <= '0;
            cur_c <= '0;
            state <= SCAN;
          end else tries <= tries + TW'(1);
        SCAN: begin
          state <= !bus.pcTurn ? IDLE : !mask[cur_i] ? THINK : scan_end ? DONE : SCAN;
          if (bus.pcTurn && mask[cur_i] && !scan_end) begin
            cur_c <= cur_c == 3'(COLS - 1) ? 3'd0 : cur_c + 3'd1;
            cur_r <= cur_c == 3'(COLS - 1) ? cur_r + 3'd1 : cur_r;
          end
        end
        THINK: begin
          cnt <= cnt - 32'd1;
          state <= !bus.pcTurn ? IDLE : cnt == 32'd0 ? FIRE : THINK;
        end
        FIRE: begin
          mask[cur_i] <= 1'b1;
          bus.shotHit <= bus.playerBoard[cur_i];
          bus.shotRow <= cur_r;
          bus.shotCol <= cur_c;
          bus.shotDone <= 1'b1;
          if (bus.playerBoard[cur_i] && bus.playerBoats != 3'd0) bus.playerBoats <= bus.playerBoats - 3'd1;
`ifdef PC_HUNT_EN
          if (bus.playerBoard[cur_i]) begin
            hunt_v <= 1'b1;
            hunt_r <= cur_r;
            hunt_c <= cur_c;
          end
`endif
          state <= DONE;
        end
        DONE: state <= bus.pcTurn ? DONE : IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pc_shot_engine.sv
// tb_pc_shot_engine: directed bench for pc_shot_engine on a 5x5 board with a 4-cycle think delay.
`timescale 1ns/1ps
module tb_pc_shot_engine;
  import battleship_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  bit seen [5][5];
  pc_shot_engine_if #(.ROWS(5), .COLS(5)) bus ();
  pc_shot_engine #(.ROWS(5), .COLS(5), .BOATS(5), .THINK_CYCLES(4), .MAX_TRIES(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic pulse_new_game;
    @(negedge clk);
    bus.newGame = 1'b1;
    @(negedge clk);
    bus.newGame = 1'b0;
  endtask
  // One PC turn: latency must lie in 7..47 cycles (1 + 16 + 25 + 4 + 1 worst case).
  task automatic turn(input bit want, output bit got, output coord_t r, output coord_t c,
                      output logic h, output logic w0, output logic w1);
    int n = 0;
    got = 1'b0; r = '0; c = '0; h = 1'b0; w0 = 1'b0; w1 = 1'b0;
    bus.pcTurn = 1'b1;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.shotDone === 1'b1) begin
        got = 1'b1; r = bus.shotRow; c = bus.shotCol; h = bus.shotHit; w0 = bus.pcWin;
      end
    end
    checks++;
    if (got !== want) begin errors++; $display("FAIL turn_shot: shot=%0b expected=%0b", got, want); end
    if (got) begin
      checks++;
      if (n < 7 || n > 47) begin errors++; $display("FAIL turn_latency: %0d cycles, expected 7..47", n); end
      @(negedge clk);
      w1 = bus.pcWin;
      checks++;
      if (bus.shotDone !== 1'b0) begin errors++; $display("FAIL pulse_width: shotDone=%b expected 0", bus.shotDone); end
      n = 0;
      repeat (10) begin @(negedge clk); if (bus.shotDone !== 1'b0) n++; end
      checks++;
      if (n != 0) begin errors++; $display("FAIL extra_pulse: %0d pulses, expected 0", n); end
    end
    bus.pcTurn = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset;
    bus.newGame = 1'b0; bus.pcTurn = 1'b0; bus.playerBoard = '0; rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks += 6;
    if (bus.shotDone !== 1'b0) begin errors++; $display("FAIL reset_shotDone: %b expected 0", bus.shotDone); end
    if (bus.shotRow !== 3'd0) begin errors++; $display("FAIL reset_shotRow: %0d expected 0", bus.shotRow); end
    if (bus.shotCol !== 3'd0) begin errors++; $display("FAIL reset_shotCol: %0d expected 0", bus.shotCol); end
    if (bus.shotHit !== 1'b0) begin errors++; $display("FAIL reset_shotHit: %b expected 0", bus.shotHit); end
    if (bus.playerBoats !== 3'd5) begin errors++; $display("FAIL reset_boats: %0d expected 5", bus.playerBoats); end
    if (bus.pcWin !== 1'b0) begin errors++; $display("FAIL reset_pcWin: %b expected 0", bus.pcWin); end
  endtask
  task automatic test_single_miss;
    bit got; coord_t r, c; logic h, w0, w1;
    bus.playerBoard = '0;
    turn(1'b1, got, r, c, h, w0, w1);
    checks += 3;
    if (h !== 1'b0) begin errors++; $display("FAIL miss_hit: %b expected 0", h); end
    if (bus.playerBoats !== 3'd5) begin errors++; $display("FAIL miss_boats: %0d expected 5", bus.playerBoats); end
    if (r >= 3'd5 || c >= 3'd5) begin errors++; $display("FAIL miss_range: (%0d,%0d) expected <5", r, c); end
  endtask
  task automatic test_all_hits;
    bit got; coord_t r, c; logic h, w0, w1;
    pulse_new_game();
    bus.playerBoard = '1;
    for (int i = 0; i < 5; i++) begin
      turn(1'b1, got, r, c, h, w0, w1);
      checks += 4;
      if (h !== 1'b1) begin errors++; $display("FAIL hits_hit%0d: %b expected 1", i, h); end
      if (bus.playerBoats !== 3'(4 - i)) begin errors++; $display("FAIL hits_boats%0d: %0d expected %0d", i, bus.playerBoats, 4 - i); end
      if (w0 !== 1'b0) begin errors++; $display("FAIL hits_win_early%0d: %b expected 0", i, w0); end
      if (w1 !== (i == 4)) begin errors++; $display("FAIL hits_win_next%0d: %b expected %0b", i, w1, i == 4); end
    end
    turn(1'b0, got, r, c, h, w0, w1);
    checks += 2;
    if (bus.playerBoats !== 3'd0) begin errors++; $display("FAIL win_boats: %0d expected 0", bus.playerBoats); end
    if (bus.pcWin !== 1'b1) begin errors++; $display("FAIL win_level: %b expected 1", bus.pcWin); end
    pulse_new_game();
    @(negedge clk);
    checks += 3;
    if (bus.pcWin !== 1'b0) begin errors++; $display("FAIL newgame_pcWin: %b expected 0", bus.pcWin); end
    if (bus.playerBoats !== 3'd5) begin errors++; $display("FAIL newgame_boats: %0d expected 5", bus.playerBoats); end
    if (bus.shotHit !== 1'b0) begin errors++; $display("FAIL newgame_shotHit: %b expected 0", bus.shotHit); end
  endtask
  // pcTurn dropped 5 cycles after rising, before the earliest possible fire at cycle 7.
  task automatic test_abort;
    int n = 0;
    bus.pcTurn = 1'b1;
    repeat (5) begin @(negedge clk); if (bus.shotDone !== 1'b0) n++; end
    bus.pcTurn = 1'b0;
    repeat (60) begin @(negedge clk); if (bus.shotDone !== 1'b0) n++; end
    checks++;
    if (n != 0) begin errors++; $display("FAIL abort_shot: %0d pulses, expected 0", n); end
  endtask
  task automatic test_sweep;
    bit got; coord_t r, c; logic h, w0, w1;
    pulse_new_game();
    bus.playerBoard = '0;
    foreach (seen[i, j]) seen[i][j] = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (i == 12) test_abort();
      turn(1'b1, got, r, c, h, w0, w1);
      checks++;
      if (!(r < 3'd5 && c < 3'd5 && !seen[r][c] && h === 1'b0)) begin
        errors++; $display("FAIL sweep_cell%0d: (%0d,%0d) hit=%b, expected a fresh in-range miss", i, r, c, h);
      end else seen[r][c] = 1'b1;
    end
    turn(1'b0, got, r, c, h, w0, w1);
    checks++;
    if (bus.playerBoats !== 3'd5) begin errors++; $display("FAIL sweep_boats: %0d expected 5", bus.playerBoats); end
  endtask
  // Reference run from reset measures the fire cycle; an identical rerun pulses newGame on it.
  task automatic test_newgame_fire;
    int lat = 0;
    int n = 0;
    bit got = 1'b0;
    bus.playerBoard = '1;
    bus.pcTurn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    bus.pcTurn = 1'b1;
    while (!got && lat < 100) begin @(negedge clk); lat++; got = bus.shotDone === 1'b1; end
    checks++;
    if (!got || bus.playerBoats !== 3'd4 || bus.shotHit !== 1'b1) begin
      errors++; $display("FAIL ref_shot: done=%0b boats=%0d hit=%b, expected 1/4/1", got, bus.playerBoats, bus.shotHit);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.playerBoats !== 3'd5 || bus.shotHit !== 1'b0 || bus.shotDone !== 1'b0 || bus.pcWin !== 1'b0 ||
        bus.shotRow !== 3'd0 || bus.shotCol !== 3'd0) begin
      errors++; $display("FAIL async_reset: boats=%0d hit=%b done=%b win=%b row=%0d col=%0d, expected 5/0/0/0/0/0",
                         bus.playerBoats, bus.shotHit, bus.shotDone, bus.pcWin, bus.shotRow, bus.shotCol);
    end
    bus.pcTurn = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    bus.pcTurn = 1'b1;
    repeat (lat - 1) @(negedge clk);
    bus.newGame = 1'b1;
    @(negedge clk);
    bus.newGame = 1'b0;
    checks += 3;
    if (bus.shotDone !== 1'b0) begin errors++; $display("FAIL ng_fire_done: %b expected 0", bus.shotDone); end
    if (bus.playerBoats !== 3'd5) begin errors++; $display("FAIL ng_fire_boats: %0d expected 5", bus.playerBoats); end
    if (bus.shotHit !== 1'b0) begin errors++; $display("FAIL ng_fire_hit: %b expected 0", bus.shotHit); end
    got = 1'b0;
    while (!got && n < 100) begin @(negedge clk); n++; got = bus.shotDone === 1'b1; end
    checks++;
    if (!got || bus.playerBoats !== 3'd4) begin
      errors++; $display("FAIL ng_fire_resume: done=%0b boats=%0d, expected 1/4", got, bus.playerBoats);
    end
    bus.pcTurn = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_single_miss();
    test_all_hits();
    test_sweep();
    test_newgame_fire();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_shot_engine.md
Name: pc_shot_engine

Overview:
- Computer-opponent shooter for the Battleship game.
- Sits beside StateMachine. While the PC turn is active it picks an unshot cell on the player board using an LFSR, waits a short "think" delay, then fires.
- Reports hit or miss and keeps the player's remaining-boat count, which drives the playerBoatsLeft seven-segment display.
- Raises pcWin when the count reaches zero.

Parameters:
- ROWS, 5, board rows (1..8).
- COLS, 5, board columns (1..8).
- BOATS, 5, single-cell player boats at game start (1..7).
- THINK_CYCLES, 50_000_000, delay between pick and fire (1 s at 50 MHz).
- MAX_TRIES, 16, LFSR draws attempted before falling back to a linear scan.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- newGame  in  1  one-cycle pulse; clears shot history and restores the boat count
- pcTurn  in  1  level; high while StateMachine is in pcState
- playerBoard  in  ROWS*COLS  boat map; bit r*COLS+c set = boat at (r,c); sampled at FIRE only
- shotDone  out  1  one-cycle pulse when a shot resolves
- shotRow  out  3  row of the last shot
- shotCol  out  3  column of the last shot
- shotHit  out  1  last shot hit a boat; held until the next shot
- playerBoats  out  3  remaining player boats
- pcWin  out  1  level; all player boats sunk

Behaviour:
- Interface fixed: one clock, clk; reset rst is asynchronous and active-low.
- Reset values:
  - state IDLE
  - shot mask all 0
  - LFSR 8'hA5
  - shotDone 0, shotRow 0, shotCol 0, shotHit 0
  - playerBoats BOATS
  - pcWin 0
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4; advances every cycle in every state.
  - Never all-zero: if it reads 0, force 8'hA5.
  - Candidate cell: row = lfsr[2:0], col = lfsr[5:3].
- FSM:
  - IDLE: move to PICK when pcTurn=1 and pcWin=0. Clear tries.
  - PICK, one draw per cycle:
    - Accept the candidate if row<ROWS, col<COLS and its mask bit is 0; go to THINK.
    - Otherwise tries++.
    - When tries reaches MAX_TRIES, go to SCAN.
  - SCAN: walk index 0..ROWS*COLS-1, one cell per cycle. The first unshot cell is taken; go to THINK. If no unshot cell exists, go to DONE with no shot fired and no shotDone pulse.
  - THINK: count THINK_CYCLES-1 down to 0, then go to FIRE.
  - FIRE, single cycle:
    - Set the mask bit.
    - shotHit = playerBoard bit.
    - Drive shotRow and shotCol.
    - Pulse shotDone.
    - On a hit with playerBoats>0, decrement playerBoats.
    - pcWin goes high in the cycle after playerBoats becomes 0.
  - DONE: hold until pcTurn=0, then go to IDLE. Exactly one shot is fired per pcTurn high period.
- Worst-case latency from pcTurn rising to shotDone: 1 + MAX_TRIES + ROWS*COLS + THINK_CYCLES + 1 cycles.
- pcTurn dropping in PICK, SCAN or THINK aborts to IDLE with no shot and no state change.
- newGame:
  - Effective in any state.
  - Returns the FSM to IDLE, clears the mask, sets playerBoats=BOATS and pcWin=0.
  - shotHit, shotRow and shotCol are cleared.
  - The LFSR is not reseeded.
  - newGame has priority over a FIRE in the same cycle; that shot is discarded.
- playerBoats saturates at 0; a hit on a stale board bit never underflows it.
- While pcWin=1 the engine ignores pcTurn.
- Reset asserted mid-operation immediately forces all reset values.

Optional Feature:
- Macro PC_HUNT_EN.
- When defined, after a hit the engine stores the hit cell. The next PICK first tries its four neighbours in order up, right, down, left, one per cycle. Out-of-range or already-shot neighbours are skipped. If all four fail, normal LFSR draws resume, and the hunt target is then cleared.
- When undefined, no hunt state or storage exists and behaviour is as above.

Decomposition:
- Shared package battleship_pkg holds:
  - the FSM state enum (IDLE, PICK, SCAN, THINK, FIRE, DONE)
  - default ROWS, COLS, BOATS
  - LFSR seed 8'hA5
  - the coordinate typedef logic[2:0]
- One natural sub-module: lfsr8, a free-running 8-bit LFSR with async active-low reset and zero-lock guard, reusable by ShootCoordSelector tests.

Test Plan:
- Reset release, then pcTurn=1 with THINK_CYCLES=4 and playerBoard all 0 → one shotDone pulse, shotHit=0, playerBoats=5; no further pulse until pcTurn toggles.
- playerBoard all 1, 5 turns → playerBoats steps 4,3,2,1,0; pcWin=1 one cycle after the 5th shotDone; a 6th pcTurn produces no shot.
- 25 turns on a 5x5 board with no boats → 25 distinct (row,col) pairs, all <5; a 26th turn produces no shotDone.
- pcTurn dropped during THINK → no shotDone and mask unchanged; the next full turn fires normally.
- newGame pulse coincident with FIRE → no shotDone, playerBoats=5, mask cleared, shotHit=0.
- With PC_HUNT_EN: a hit at (2,2) → the next shot is at (1,2), the up neighbour; if (1,2) is pre-shot, the next shot is at (2,3).
